logic_unit_arbiter: RTL and testbench
=====================================

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand/result bit width.
REQ-002 Parameter NREQ, default 4, number of requesters (2..8); IDW = $clog2(NREQ).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  one-hot acceptance pulse to the granted requester.
REQ-007 req_op  input  3*NREQ  opcode per requester, slice i at [3i+2:3i].
REQ-008 req_a, req_b  input  WIDTH*NREQ  operands per requester, slice i at [WIDTH*i +: WIDTH].
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts the result.
REQ-011 rsp_id  output  IDW  index of the requester that owns the result.
REQ-012 rsp_data  output  WIDTH  result.
REQ-013 rsp_err  output  1  illegal opcode flag.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 Opcode map, bitwise on WIDTH bits: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XNOR, 5 NOT a (b ignored), 6 XOR, 7 illegal.
REQ-016 Opcode 7 yields rsp_data=0 and rsp_err=1; all other opcodes yield rsp_err=0.
REQ-017 FSM states: IDLE, EXEC, RESP; one operation in flight at a time.
REQ-018 IDLE: if any req_valid is high, grant one requester, pulse req_ready[g] for exactly that cycle, latch op/a/b/g, and go to EXEC. Otherwise stay in IDLE.
REQ-019 EXEC: register the result, id and err, and go to RESP. This state always lasts one cycle.
REQ-020 RESP: hold rsp_valid=1 with stable rsp_id/rsp_data/rsp_err until rsp_ready=1. On that cycle, go to IDLE.
REQ-021 Latency: rsp_valid rises 2 cycles after the req_ready pulse. Minimum issue interval is 3 cycles.
REQ-022 Round-robin grant: search starts at pointer ptr and wraps from NREQ-1 to 0. The first valid requester found is granted.
REQ-023 ptr resets to 0 and updates to (g+1) mod NREQ at the grant cycle only.
REQ-024 A requester dropping req_valid before its grant is not served. Operands are sampled only at the grant edge.
REQ-025 rsp_ready while not in RESP is ignored. rsp_valid is never high outside RESP.

Reset
REQ-026 While rst_n=0, regardless of clk: state=IDLE, ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0.
REQ-027 Reset asserted mid-operation discards the operation; nothing is replayed after release.

Configuration
REQ-028 Macro LOGIC_ARB_PRIO0_EN defined: requester 0 wins whenever its req_valid is high; otherwise round-robin among 1..NREQ-1. ptr is not updated on a priority-0 grant.
REQ-029 Macro undefined: pure round-robin per REQ-022/023 for all requesters.

Structure
REQ-030 A shared package logic_arb_pkg holds the opcode localparams (OP_AND..OP_ILLEGAL), the state encoding and the 3-bit opcode width constant.
REQ-031 Combinational sub-module logic_unit (op, a, b -> y, err) implements REQ-015/016. The arbiter instantiates it once.

Verification
REQ-032 Reset: rst_n=0 with random inputs -> all outputs 0. Release with req_valid=0 -> stays idle, busy=0.
REQ-033 Single request: req 2, op=6, a=8'hF0, b=8'h3C -> req_ready=4'b0100. Two cycles later rsp_valid=1, rsp_id=2, rsp_data=8'hCC, rsp_err=0.
REQ-034 Opcode sweep: req 0, a=8'hA5, b=8'h0F, ops 0..7 -> rsp_data 05, AF, FA, 50, 55, 5A, AA, 00. err=1 only for op 7.
REQ-035 Fairness: all four req_valid held high, rsp_ready=1 (macro off) -> grant order 0,1,2,3,0. With LOGIC_ARB_PRIO0_EN -> 0,0,0,... until req 0 drops, then 1,2,3.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable, no req_ready pulses. rsp_ready=1 -> next grant one cycle later.
REQ-037 Mid-op reset: rst_n pulsed low during EXEC -> outputs 0 immediately. After release, no rsp_valid occurs without a new request.

Source files
------------

// File: rtl/logic_arb_pkg.sv
// ---------------------------------------------------------------------------
// logic_arb_pkg
// Shared definitions for the logic-unit arbiter slice:
//   - OPW          : opcode width (3 bits)
//   - OP_AND..OP_ILLEGAL : opcode encodings understood by logic_unit
//   - state_t      : arbiter FSM state encoding (IDLE / EXEC / RESP)
// ---------------------------------------------------------------------------
package logic_arb_pkg;

    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_AND     = 3'd0;
    localparam logic [OPW-1:0] OP_OR      = 3'd1;
    localparam logic [OPW-1:0] OP_NAND    = 3'd2;
    localparam logic [OPW-1:0] OP_NOR     = 3'd3;
    localparam logic [OPW-1:0] OP_XNOR    = 3'd4;
    localparam logic [OPW-1:0] OP_NOT     = 3'd5;
    localparam logic [OPW-1:0] OP_XOR     = 3'd6;
    localparam logic [OPW-1:0] OP_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_unit.sv
// ---------------------------------------------------------------------------
// logic_unit
// Purely combinational bitwise logic operator.
// Ports:
//   op  [2:0]        opcode (see logic_arb_pkg)
//   a   [WIDTH-1:0]  operand A
//   b   [WIDTH-1:0]  operand B (ignored for OP_NOT)
//   y   [WIDTH-1:0]  result, zero for the illegal opcode
//   err              high only for the illegal opcode
// ---------------------------------------------------------------------------
module logic_unit
    import logic_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_XOR:  y = a ^ b;
            default: begin
                y   = '0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// logic_unit_arbiter
// Round-robin arbiter in front of a single shared logic_unit. One operation
// is in flight at a time: IDLE (grant) -> EXEC (compute) -> RESP (hold until
// consumed).
//
// Optional feature: define LOGIC_ARB_PRIO0_EN to give requester 0 absolute
// priority; the remaining requesters then share round-robin among themselves.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid [NREQ-1:0]          per-requester request
//   req_ready [NREQ-1:0]          one-cycle one-hot acceptance pulse
//   req_op    [3*NREQ-1:0]        opcode per requester, slice i = [3i+2:3i]
//   req_a/b   [WIDTH*NREQ-1:0]    operands per requester, slice i = [WIDTH*i +: WIDTH]
//   rsp_valid / rsp_ready         result handshake
//   rsp_id    [IDW-1:0]           owner of the result
//   rsp_data  [WIDTH-1:0]         result
//   rsp_err                       illegal opcode flag
//   busy                          high whenever not IDLE
// ---------------------------------------------------------------------------
module logic_unit_arbiter
    import logic_arb_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [OPW*NREQ-1:0]   req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);

    state_t           state_reg, state_next;
    logic [IDW-1:0]   ptr_reg, ptr_next;

    logic [OPW-1:0]   op_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [IDW-1:0]   gid_reg;

    logic [IDW-1:0]   rsp_id_reg;
    logic [WIDTH-1:0] rsp_data_reg;
    logic             rsp_err_reg;

    logic             do_grant;
    logic             do_exec;

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
    logic [NREQ-1:0]  rr_valid;
    logic [IDW-1:0]   cand_idx [NREQ];
    logic             rr_found;
    logic [IDW-1:0]   rr_idx;
    logic             grant_any;
    logic [IDW-1:0]   grant_idx;
    logic             ptr_upd;

`ifdef LOGIC_ARB_PRIO0_EN
    // Requester 0 is handled by the priority path, so hide it from the
    // round-robin search.
    assign rr_valid = {req_valid[NREQ-1:1], 1'b0};
`else
    assign rr_valid = req_valid;
`endif

    // Candidate k of the search is (ptr + k) mod NREQ.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IDW:0] sum;
            assign sum          = {1'b0, ptr_reg} + (IDW+1)'(gi);
            assign cand_idx[gi] = (sum >= (IDW+1)'(NREQ))
                                ? IDW'(sum - (IDW+1)'(NREQ))
                                : sum[IDW-1:0];
        end
    endgenerate

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!rr_found && rr_valid[cand_idx[k]]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx[k];
            end
        end
    end

    always_comb begin
`ifdef LOGIC_ARB_PRIO0_EN
        grant_any = req_valid[0] | rr_found;
        grant_idx = req_valid[0] ? '0 : rr_idx;
        ptr_upd   = ~req_valid[0];
`else
        grant_any = rr_found;
        grant_idx = rr_idx;
        ptr_upd   = 1'b1;
`endif
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        do_grant   = 1'b0;
        do_exec    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (grant_any) begin
                    do_grant   = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                do_exec    = 1'b1;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (do_grant && ptr_upd) begin
            ptr_next = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    // ---------------------------------------------------------------------
    // Operand capture (grant edge only) and result registers (EXEC edge)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg  <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            gid_reg <= '0;
        end else if (do_grant) begin
            op_reg  <= req_op[OPW*grant_idx +: OPW];
            a_reg   <= req_a[WIDTH*grant_idx +: WIDTH];
            b_reg   <= req_b[WIDTH*grant_idx +: WIDTH];
            gid_reg <= grant_idx;
        end
    end

    logic [WIDTH-1:0] lu_y;
    logic             lu_err;

    logic_unit #(
        .WIDTH (WIDTH)
    ) u_logic_unit (
        .op  (op_reg),
        .a   (a_reg),
        .b   (b_reg),
        .y   (lu_y),
        .err (lu_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id_reg   <= '0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else if (do_exec) begin
            rsp_id_reg   <= gid_reg;
            rsp_data_reg <= lu_y;
            rsp_err_reg  <= lu_err;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    // req_ready is combinational from req_valid, so it is also gated by
    // rst_n to stay low while reset is held, independent of the clock.
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = rst_n & do_grant & (grant_idx == IDW'(gi));
        end
    endgenerate

    assign rsp_valid = (state_reg == ST_RESP);
    assign busy      = (state_reg != ST_IDLE);
    assign rsp_id    = rsp_id_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;
    import logic_arb_pkg::*;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [3*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_err;
    logic                  busy;

    int n_vec;
    int n_err;

    logic_unit_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[3*id +: 3]         = op;
        req_a[WIDTH*id +: WIDTH]  = a;
        req_b[WIDTH*id +: WIDTH]  = b;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Full single-request transaction with rsp_ready held low until the
    // result has been checked.
    task automatic do_op(input int id, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_d, input logic exp_e);
        set_req(id, op, a, b);
        req_valid = 4'(1 << id);
        #1;
        check($sformatf("op%0d ready", op), req_ready, 32'(1 << id));
        step();
        req_valid = '0;
        check($sformatf("op%0d busy", op), busy, 1);
        check($sformatf("op%0d early valid", op), rsp_valid, 0);
        step();
        check($sformatf("op%0d valid", op), rsp_valid, 1);
        check($sformatf("op%0d id", op), rsp_id, id);
        check($sformatf("op%0d data", op), rsp_data, exp_d);
        check($sformatf("op%0d err", op), rsp_err, exp_e);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check($sformatf("op%0d done", op), rsp_valid, 0);
    endtask

    logic [7:0] sweep_exp [8] = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'h55, 8'h5A, 8'hAA, 8'h00};
`ifdef LOGIC_ARB_PRIO0_EN
    int grant_exp [6] = '{0, 0, 0, 1, 2, 3};
`else
    int grant_exp [6] = '{0, 1, 2, 3, 0, 1};
`endif

    initial begin
        n_vec = 0;
        n_err = 0;

        // Reset with random inputs
        rst_n     = 1'b0;
        req_valid = 4'($urandom_range(1, 15));
        req_op    = 12'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        rsp_ready = 1'($urandom);
        step();
        step();
        check("rst req_ready", req_ready, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst rsp_id", rsp_id, 0);
        check("rst rsp_data", rsp_data, 0);
        check("rst rsp_err", rsp_err, 0);
        check("rst busy", busy, 0);
        req_valid = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle busy", busy, 0);
            check("idle valid", rsp_valid, 0);
        end

        // Single request: XOR on requester 2
        do_op(2, OP_XOR, 8'hF0, 8'h3C, 8'hCC, 1'b0);

        // Opcode sweep on requester 0
        for (int op = 0; op < 8; op++) begin
            do_op(0, 3'(op), 8'hA5, 8'h0F, sweep_exp[op], (op == 7));
        end

        // Fairness with all requesters active
        pulse_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, OP_OR, 8'(i), 8'h00);
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        #1;
        for (int g = 0; g < 6; g++) begin
            int w;
            w = 0;
            while (req_ready == '0 && w < 6) begin
                step();
                w++;
            end
            check($sformatf("grant %0d", g), req_ready, 32'(1 << grant_exp[g]));
            step();
            step();
            check($sformatf("grant %0d rsp_id", g), rsp_id, grant_exp[g]);
            check($sformatf("grant %0d rsp_data", g), rsp_data, grant_exp[g]);
`ifdef LOGIC_ARB_PRIO0_EN
            if (g == 2) req_valid[0] = 1'b0;
`endif
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        step();

        // Backpressure
        pulse_reset();
        set_req(1, OP_OR, 8'h12, 8'h21);
        set_req(3, OP_ILLEGAL, 8'hFF, 8'hFF);
        req_valid = 4'b0010;
        #1;
        check("bp grant1", req_ready, 32'b0010);
        step();
        req_valid = 4'b1010;
        #1;
        check("bp exec ready", req_ready, 0);
        step();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp c%0d valid", c), rsp_valid, 1);
            check($sformatf("bp c%0d data", c), rsp_data, 8'h33);
            check($sformatf("bp c%0d id", c), rsp_id, 1);
            check($sformatf("bp c%0d ready", c), req_ready, 0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        check("bp regrant", req_ready, 32'b1000);
        check("bp regrant busy", busy, 0);
        step();
        req_valid = '0;
        step();
        check("bp ill valid", rsp_valid, 1);
        check("bp ill id", rsp_id, 3);
        check("bp ill data", rsp_data, 0);
        check("bp ill err", rsp_err, 1);
        step();
        check("bp ill done", rsp_valid, 0);
        rsp_ready = 1'b0;

        // Reset during EXEC
        do_op(2, OP_OR, 8'hC0, 8'h0C, 8'hCC, 1'b0);
        set_req(0, OP_AND, 8'hFF, 8'hFF);
        req_valid = 4'b0001;
        step();
        check("mid in exec", busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid req_ready", req_ready, 0);
        check("mid busy", busy, 0);
        check("mid rsp_valid", rsp_valid, 0);
        check("mid rsp_id", rsp_id, 0);
        check("mid rsp_data", rsp_data, 0);
        check("mid rsp_err", rsp_err, 0);
        req_valid = '0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post rst valid", rsp_valid, 0);
            check("post rst busy", busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
